// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Segment patterns and decode helpers for the 7-segment scan driver.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    // Active-high patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] pat;
        case (nibble)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    pat = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    pat = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    pat = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    pat = hex_mode ? SEG_E : SEG_BLANK;
            default: pat = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decoder
// Brief    : Combinational nibble to active-high {a..g} segment pattern.
// Revision : 1.0
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = seg7_decode(nibble, HEX_MODE != 0);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed N-digit 7-segment driver with frame-aligned
//            updates and optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int HEX_MODE       = 0,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int IDX_W   = idx_width(NUM_DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_sh_val;
    logic [NUM_DIGITS-1:0] r_sh_dp;
    logic                  r_sh_blz;
    logic                  r_pending;
    logic [VAL_W-1:0]      r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic [NUM_DIGITS-1:0] r_lz_mask;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_tc;
    logic                  w_boundary;
    logic [IDX_W-1:0]      w_idx_next;
    logic [NUM_DIGITS-1:0] w_lz_next;
    logic                  w_lz_run;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [3:0]            w_nib;
    logic                  w_dp_bit;
    logic                  w_blank_bit;
    logic [6:0]            w_pattern;
    logic [6:0]            w_seg_hi;
    logic [6:0]            w_seg_next;
    logic                  w_dp_next;
    logic [NUM_DIGITS-1:0] w_an_lit;

    assign w_tc       = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_boundary = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_idx_next = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);

    // Blank zero nibbles from the MSD downward until the first non-zero; digit 0 always shows.
    always_comb begin
        w_lz_next = '0;
        w_lz_run  = r_sh_blz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (w_lz_run && (r_sh_val[4*k +: 4] == 4'h0)) begin
                w_lz_next[k] = 1'b1;
            end else begin
                w_lz_run = 1'b0;
            end
        end
    end

    always_comb begin
        w_onehot    = '0;
        w_nib       = 4'h0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_nib       = r_disp_val[4*k +: 4];
                w_dp_bit    = r_disp_dp[k];
                w_blank_bit = r_lz_mask[k];
            end
        end
    end

    seg7_decoder #(
        .HEX_MODE (HEX_MODE)
    ) u_decoder (
        .nibble  (w_nib),
        .pattern (w_pattern)
    );

    assign w_seg_hi   = w_blank_bit ? SEG_BLANK : w_pattern;
    assign w_seg_next = (ACTIVE_LOW_SEG != 0) ? ~w_seg_hi : w_seg_hi;
    assign w_dp_next  = (ACTIVE_LOW_SEG != 0) ? ~w_dp_bit : w_dp_bit;
    assign w_an_lit   = (ACTIVE_LOW_AN != 0) ? ~w_onehot : w_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_sh_val   <= '0;
            r_sh_dp    <= '0;
            r_sh_blz   <= 1'b0;
            r_pending  <= 1'b0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_lz_mask  <= '0;
            r_seg      <= SEG_OFF;
            r_dp       <= DP_OFF;
            r_an       <= AN_OFF;
        end else begin
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= w_idx_next;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end

            // Display only swaps on a frame boundary, so a frame never mixes two words.
            if (w_boundary && r_pending) begin
                r_disp_val <= r_sh_val;
                r_disp_dp  <= r_sh_dp;
                r_lz_mask  <= w_lz_next;
            end

            if (load) begin
                r_sh_val  <= value;
                r_sh_dp   <= dp_in;
                r_sh_blz  <= blank_lz;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end

            // Digit enable dropped for the cycle after each idx change to avoid ghosting.
            r_an  <= (enable && !w_tc) ? w_an_lit : AN_OFF;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;
    assign frame_start = w_boundary;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed self-checking bench; decimal-only and hex-mode instances share stimulus.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fs0, fs1;
    logic        pend0, pend1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0),
        .frame_start(fs0), .pending(pend0)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1),
        .frame_start(fs1), .pending(pend1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at the negedge inside the frame-boundary cycle.
    task automatic wait_fs(input string tag);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            if (fs0 === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_total++;
            $error("FAIL %s: frame_start not seen within 40 cycles", tag);
        end
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target);
        bit found = 0;
        for (int i = 0; i < 40; i++) begin
            if (an0 === target) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            n_total++;
            $error("FAIL %s: an=%b never reached %b", tag, an0, target);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
        value    = v;
        dp_in    = d;
        blank_lz = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0;
        value = 16'h0; dp_in = 4'h0; blank_lz = 1'b0;

        // Reset state
        tick(5);
        chk("rst_seg", seg0, 7'h7F);
        chk("rst_dp", dp0, 1'b1);
        chk("rst_an", an0, 4'hF);
        chk("rst_pending", pend0, 1'b0);
        chk("rst_fs", fs0, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("rel_an", an0, 4'b1110);
        chk("rel_seg", seg0, 7'b0000001);

        // Basic scan of 1234
        do_load(16'h1234, 4'h0, 1'b0);
        chk("scan_pending", pend0, 1'b1);
        wait_fs("scan_fs");
        chk("scan_pending_bnd", pend0, 1'b1);
        tick(1);
        chk("scan_pending_clr", pend0, 1'b0);
        chk("scan_gap0", an0, 4'hF);
        tick(1);
        chk("scan_d0_an", an0, 4'b1110);
        chk("scan_d0_seg", seg0, 7'b1001100);
        chk("scan_d0_dp", dp0, 1'b1);
        tick(2);
        chk("scan_d0_an_last", an0, 4'b1110);
        tick(1);
        chk("scan_gap1", an0, 4'hF);
        tick(1);
        chk("scan_d1_an", an0, 4'b1101);
        chk("scan_d1_seg", seg0, 7'b0000110);
        wait_an("scan_d3_wait", 4'b0111);
        chk("scan_d3_seg", seg0, 7'b1001111);

        // Leading-zero blanking
        do_load(16'h0070, 4'h0, 1'b1);
        wait_fs("lz_fs");
        tick(1);
        wait_an("lz_d0_wait", 4'b1110);
        chk("lz_d0_seg", seg0, 7'b0000001);
        wait_an("lz_d1_wait", 4'b1101);
        chk("lz_d1_seg", seg0, 7'b0001111);
        wait_an("lz_d2_wait", 4'b1011);
        chk("lz_d2_seg", seg0, 7'h7F);
        wait_an("lz_d3_wait", 4'b0111);
        chk("lz_d3_seg", seg0, 7'h7F);
        do_load(16'h0000, 4'h0, 1'b1);
        wait_fs("lz0_fs");
        tick(1);
        wait_an("lz0_d0_wait", 4'b1110);
        chk("lz0_d0_seg", seg0, 7'b0000001);
        wait_an("lz0_d1_wait", 4'b1101);
        chk("lz0_d1_seg", seg0, 7'h7F);
        wait_an("lz0_d3_wait", 4'b0111);
        chk("lz0_d3_seg", seg0, 7'h7F);

        // Hex vs. decimal-only codes, decimal point on digit 2
        do_load(16'hABCF, 4'b0100, 1'b0);
        wait_fs("hex_fs");
        tick(1);
        wait_an("hex_d0_wait", 4'b1110);
        chk("dec_d0_seg", seg0, 7'h7F);
        chk("hex_d0_seg", seg1, 7'b0111000);
        chk("hex_d0_dp", dp1, 1'b1);
        wait_an("hex_d2_wait", 4'b1011);
        chk("dec_d2_seg", seg0, 7'h7F);
        chk("dec_d2_dp", dp0, 1'b0);
        chk("hex_d2_seg", seg1, 7'b1100000);
        chk("hex_d2_dp", dp1, 1'b0);
        wait_an("hex_d3_wait", 4'b0111);
        chk("dec_d3_seg", seg0, 7'h7F);
        chk("hex_d3_seg", seg1, 7'b0001000);
        chk("hex_d3_dp", dp1, 1'b1);

        // Load landing on the frame boundary
        do_load(16'h1111, 4'h0, 1'b0);
        wait_fs("race_fs1");
        do_load(16'h2222, 4'h0, 1'b0);
        chk("race_pending", pend0, 1'b1);
        wait_an("race_d0_wait", 4'b1110);
        chk("race_d0_seg", seg0, 7'b1001111);
        wait_an("race_d3_wait", 4'b0111);
        chk("race_d3_seg", seg0, 7'b1001111);
        wait_fs("race_fs2");
        tick(1);
        chk("race_pending_clr", pend0, 1'b0);
        wait_an("race2_d0_wait", 4'b1110);
        chk("race2_d0_seg", seg0, 7'b0010010);

        // Enable off: dark, scan keeps running
        enable = 1'b0;
        tick(1);
        chk("en_off_an", an0, 4'hF);
        wait_fs("en_off_fs");
        chk("en_off_an_fs", an0, 4'hF);
        tick(1);
        enable = 1'b1;

        // Reset while a load is pending
        wait_fs("rstp_fs");
        tick(1);
        do_load(16'h9999, 4'hF, 1'b0);
        chk("rstp_pending", pend0, 1'b1);
        rst_n = 1'b0;
        tick(2);
        chk("rstp_pending_clr", pend0, 1'b0);
        chk("rstp_an", an0, 4'hF);
        rst_n = 1'b1;
        tick(1);
        chk("rstp_rel_an", an0, 4'b1110);
        chk("rstp_rel_seg", seg0, 7'b0000001);
        chk("rstp_rel_dp", dp0, 1'b1);
        wait_an("rstp_d1_wait", 4'b1101);
        chk("rstp_d1_seg", seg0, 7'b0000001);
        chk("rstp_pending_after", pend0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
